// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared types, address field widths and byte helpers for the data cache.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package data_cache_pkg;

   localparam int CACHE_BLOCKS = 8;
   localparam int BLOCK_BYTES  = 4;
   localparam int ADDR_W       = 8;
   localparam int OFFSET_W     = $clog2(BLOCK_BYTES);
   localparam int INDEX_W      = $clog2(CACHE_BLOCKS);
   localparam int TAG_W        = ADDR_W - INDEX_W - OFFSET_W;
   localparam int BLOCK_W      = 32;
   localparam int MEM_ADDR_W   = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WRITEBACK = 2'b01,
      FETCH     = 2'b10
   } state_t;

   // Little-endian byte extract: offset n lives in bits [8n+7:8n].
   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFFSET_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/data_cache_line_array.sv
// data_cache_line_array: per-line valid/dirty/tag/data storage with byte write and block fill.
// Latency: reads are combinational; writes and fills take effect at the rising edge.
// Backpressure: none; the controller guarantees byte write and fill never coincide.
module data_cache_line_array
   import data_cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  idx,
   input  logic                wr_en,
   input  logic [OFFSET_W-1:0] wr_off,
   input  logic [7:0]          wr_byte,
   input  logic                fill_en,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0]  fill_data,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    tag,
   output logic [BLOCK_W-1:0]  data
);

   logic [CACHE_BLOCKS-1:0] valid_q;
   logic [CACHE_BLOCKS-1:0] dirty_q;
   logic [TAG_W-1:0]        tag_q  [CACHE_BLOCKS];
   logic [BLOCK_W-1:0]      data_q [CACHE_BLOCKS];

   // Status bits clear asynchronously; a fill makes the line clean, a byte store dirties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (wr_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; stale contents are masked by valid.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[idx]  <= fill_tag;
         data_q[idx] <= fill_data;
      end else if (wr_en) begin
         data_q[idx][{wr_off, 3'b000} +: 8] <= wr_byte;
      end
   end

   // Combinational read of the addressed line.
   always_comb begin
      valid = valid_q[idx];
      dirty = dirty_q[idx];
      tag   = tag_q[idx];
      data  = data_q[idx];
   end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate byte cache in front of a 32-bit-block memory.
// Latency: hits return READDATA in the request cycle; misses add write-back (if dirty) plus fetch.
// Backpressure: BUSYWAIT stalls the CPU on a miss; MEM_BUSYWAIT stretches WRITEBACK and FETCH.
module data_cache
   import data_cache_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_W-1:0]     ADDRESS,
   input  logic [7:0]            WRITEDATA,
   output logic [7:0]            READDATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]    MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   state_t               state;
   state_t               next_state;
   logic                 armed;
   logic [TAG_W-1:0]     addr_tag;
   logic [INDEX_W-1:0]   addr_index;
   logic [OFFSET_W-1:0]  addr_offset;
   logic                 line_valid;
   logic                 line_dirty;
   logic [TAG_W-1:0]     line_tag;
   logic [BLOCK_W-1:0]   line_data;
   logic                 hit;
   logic                 idle_hit;
   logic                 req;
   logic                 mem_done;
   logic                 byte_wr;
   logic                 fill;

   assign addr_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
   assign addr_index  = ADDRESS[OFFSET_W +: INDEX_W];
   assign addr_offset = ADDRESS[OFFSET_W-1:0];

   assign req      = READ | WRITE;
   assign hit      = line_valid & (line_tag == addr_tag);
   assign idle_hit = (state == IDLE) & hit;
   // The first edge in WRITEBACK/FETCH is ignored so memory may raise its busy one cycle late.
   assign mem_done = armed & ~MEM_BUSYWAIT;
   // WRITE wins when both strobes are high, so a combined request is handled as a store.
   assign byte_wr  = WRITE & idle_hit;
   assign fill     = (state == FETCH) & mem_done;

   data_cache_line_array u_lines (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .idx       (addr_index),
      .wr_en     (byte_wr),
      .wr_off    (addr_offset),
      .wr_byte   (WRITEDATA),
      .fill_en   (fill),
      .fill_tag  (addr_tag),
      .fill_data (MEM_READDATA),
      .valid     (line_valid),
      .dirty     (line_dirty),
      .tag       (line_tag),
      .data      (line_data)
   );

   // State register; armed is high from the second cycle of a memory state onward.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= next_state;
         armed <= (state != IDLE) && (next_state == state);
      end
   end

   // Next state: dirty victims are written back before the fetch; a fill returns to IDLE to retry as a hit.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               next_state = (line_valid && line_dirty) ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            if (mem_done) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            if (mem_done) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs: memory strobes per state, CPU stall and gated read byte.
   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      READDATA      = idle_hit ? get_byte(line_data, addr_offset) : 8'h00;
      BUSYWAIT      = RESET_N & req & ~idle_hit;
      case (state)
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {line_tag, addr_index};
            MEM_WRITEDATA = line_data;
         end
         FETCH: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[ADDR_W-1:OFFSET_W];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed plus randomized accesses checked against an array-level cache model.
// Latency: bench memory holds busy for a chosen number of cycles, optionally raising it one cycle late.
// Backpressure: each CPU access waits, bounded, for BUSYWAIT to fall.
module tb_data_cache;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   data_cache dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   // Initial memory image; block 0 holds 0x44332211.
   function automatic logic [31:0] init_pat(input logic [5:0] a);
      return 32'h9E3779B9 * {26'd0, a} + 32'h44332211;
   endfunction

   // Bench memory: busy for lat cycles (or cycles 1..lat when late), first cycle never completes.
   int          lat  = 5;
   bit          late = 1'b0;
   int          mcnt;
   logic [31:0] ram [64];
   bit   [63:0] ram_wr;
   logic        mem_req;

   assign mem_req      = MEM_READ | MEM_WRITE;
   assign MEM_BUSYWAIT = mem_req && (late ? (mcnt >= 1 && mcnt <= lat) : (mcnt < lat));
   assign MEM_READDATA = ram_wr[MEM_ADDRESS] ? ram[MEM_ADDRESS] : init_pat(MEM_ADDRESS);

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mcnt <= 0;
      end else if (mem_req && !MEM_BUSYWAIT && mcnt != 0) begin
         mcnt <= 0;
         if (MEM_WRITE) begin
            ram[MEM_ADDRESS]    <= MEM_WRITEDATA;
            ram_wr[MEM_ADDRESS] <= 1'b1;
         end
      end else if (mem_req) begin
         mcnt <= mcnt + 1;
      end else begin
         mcnt <= 0;
      end
   end

   // Reference model: plain arrays for the cache lines and the backing store.
   bit   [7:0]  m_valid;
   bit   [7:0]  m_dirty;
   logic [2:0]  m_tag  [8];
   logic [31:0] m_data [8];
   logic [31:0] ref_mem [64];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                         output logic [7:0] rd_out);
      logic [2:0]  idx;
      logic [2:0]  tg;
      int          off;
      bit          hit;
      bit          exp_wb;
      logic [5:0]  exp_wb_addr;
      logic [31:0] exp_wb_data;
      logic [7:0]  exp_rd;
      int          exp_stall;
      int          stall;
      bit          done;
      bit          wb_seen;
      bit          fe_seen;
      bit          both;
      bit          order_bad;
      logic [5:0]  wb_addr;
      logic [31:0] wb_data;
      logic [5:0]  fe_addr;

      idx         = a[4:2];
      tg          = a[7:5];
      off         = int'(a[1:0]);
      hit         = m_valid[idx] && (m_tag[idx] == tg);
      exp_wb      = 1'b0;
      exp_wb_addr = '0;
      exp_wb_data = '0;
      exp_rd      = 8'h00;
      if (!hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            exp_wb               = 1'b1;
            exp_wb_addr          = {m_tag[idx], idx};
            exp_wb_data          = m_data[idx];
            ref_mem[exp_wb_addr] = m_data[idx];
         end
         m_data[idx]  = ref_mem[a[7:2]];
         m_tag[idx]   = tg;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         m_data[idx][8*off +: 8] = wd;
         m_dirty[idx]            = 1'b1;
      end else begin
         exp_rd = m_data[idx][8*off +: 8];
      end
      exp_stall = hit ? 0 : 1 + (exp_wb ? 2 : 1) * (lat + 1 + int'(late));

      READ      = !wr;
      WRITE     = wr;
      ADDRESS   = a;
      WRITEDATA = wd;
      stall     = 0;
      done      = 1'b0;
      wb_seen   = 1'b0;
      fe_seen   = 1'b0;
      both      = 1'b0;
      order_bad = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      fe_addr   = '0;
      rd_out    = 8'h00;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge CLK);
         if (MEM_READ && MEM_WRITE) both = 1'b1;
         if (MEM_WRITE) begin
            if (!wb_seen) begin
               wb_addr = MEM_ADDRESS;
               wb_data = MEM_WRITEDATA;
            end
            wb_seen = 1'b1;
            if (fe_seen) order_bad = 1'b1;
         end
         if (MEM_READ) begin
            if (!fe_seen) fe_addr = MEM_ADDRESS;
            fe_seen = 1'b1;
         end
         if (!BUSYWAIT) begin
            done   = 1'b1;
            rd_out = READDATA;
         end else begin
            stall++;
         end
      end
      check_eq("access_done", 32'(done), 32'd1);
      check_eq("stall_cycles", 32'(stall), 32'(exp_stall));
      check_eq("writeback_seen", 32'(wb_seen), 32'(exp_wb));
      if (exp_wb) begin
         check_eq("wb_addr", 32'(wb_addr), 32'(exp_wb_addr));
         check_eq("wb_data", wb_data, exp_wb_data);
      end
      check_eq("fetch_seen", 32'(fe_seen), 32'(!hit));
      if (!hit) check_eq("fetch_addr", 32'(fe_addr), 32'(a[7:2]));
      check_eq("rd_wr_exclusive", 32'(both), 32'd0);
      check_eq("wb_before_fetch", 32'(order_bad), 32'd0);
      if (!wr) check_eq("readdata", 32'(rd_out), 32'(exp_rd));

      @(posedge CLK);
      #1;
      READ  = 1'b0;
      WRITE = 1'b0;
      #1;
      check_eq("idle_busywait", 32'(BUSYWAIT), 32'd0);
      check_eq("idle_mem_req", 32'({MEM_READ, MEM_WRITE}), 32'd0);
   endtask

   logic [7:0] rd;
   bit         seen;

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(6'(i));
      m_valid   = '0;
      m_dirty   = '0;
      RESET_N   = 1'b0;
      READ      = 1'b1;
      WRITE     = 1'b0;
      ADDRESS   = 8'h00;
      WRITEDATA = 8'h00;
      #3;
      check_eq("rst_busywait", 32'(BUSYWAIT), 32'd0);
      check_eq("rst_mem_read", 32'(MEM_READ), 32'd0);
      check_eq("rst_mem_write", 32'(MEM_WRITE), 32'd0);
      check_eq("rst_readdata", 32'(READDATA), 32'd0);
      check_eq("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
      check_eq("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
      @(negedge CLK);
      READ    = 1'b0;
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;

      // Directed walk through cold miss, write hit, dirty and clean eviction, write allocate.
      lat  = 5;
      late = 1'b0;
      access(1'b0, 8'h00, 8'h00, rd);
      check_eq("cold_read_byte0", 32'(rd), 32'h11);
      access(1'b0, 8'h03, 8'h00, rd);
      check_eq("hit_read_byte3", 32'(rd), 32'h44);
      access(1'b1, 8'h01, 8'hAA, rd);
      access(1'b0, 8'h01, 8'h00, rd);
      check_eq("read_after_write", 32'(rd), 32'hAA);
      access(1'b0, 8'h21, 8'h00, rd);
      access(1'b0, 8'h01, 8'h00, rd);
      check_eq("clean_evict_reread", 32'(rd), 32'hAA);
      access(1'b1, 8'h46, 8'h55, rd);
      access(1'b0, 8'h66, 8'h00, rd);

      // Reset in the third FETCH cycle of a pending miss.
      READ    = 1'b1;
      ADDRESS = 8'h80;
      seen    = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge CLK);
         if (MEM_READ) seen = 1'b1;
      end
      check_eq("midfetch_reached", 32'(seen), 32'd1);
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check_eq("midrst_mem_read", 32'(MEM_READ), 32'd0);
      check_eq("midrst_busywait", 32'(BUSYWAIT), 32'd0);
      check_eq("midrst_readdata", 32'(READDATA), 32'd0);
      check_eq("midrst_mem_address", 32'(MEM_ADDRESS), 32'd0);
      @(negedge CLK);
      READ    = 1'b0;
      RESET_N = 1'b1;
      m_valid = '0;
      m_dirty = '0;
      @(posedge CLK);
      #1;
      access(1'b0, 8'h00, 8'h00, rd);

      // Randomized traffic over a few tags so lines conflict often.
      for (int n = 0; n < 400; n++) begin
         lat  = $urandom_range(1, 4);
         late = 1'($urandom_range(0, 1));
         access(1'($urandom_range(0, 1)),
                {3'($urandom_range(0, 3)), 5'($urandom_range(0, 31))},
                8'($urandom_range(0, 255)), rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
